pipe_trace_buffer: RTL and testbench

PIPE_TRACE_BUFFER -- requirements
Module: pipe_trace_buffer

---
 rtl/pipe_trace_buffer.sv | 186 ++++++++++++++++++
 tb/tb_pipe_trace_buffer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pipe_trace_buffer
// Brief    : Retired-instruction trace FIFO with instruction classing,
//            cycle stamps, wrap/freeze-on-full and a cycle-limit halt.
// Revision : 1.0
// ============================================================================
module pipe_trace_buffer #(
    parameter int DEPTH        = 16,
    parameter int CYC_W        = 16,
    parameter int CYCLE_LIMIT  = 500,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trc_valid,
    input  logic [31:0]              trc_pc,
    input  logic [31:0]              trc_instr,
    input  logic [31:0]              trc_wd,
    input  logic                     rearm,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [31:0]              rd_pc,
    output logic [31:0]              rd_wd,
    output logic [4:0]               rd_class,
    output logic [CYC_W-1:0]         rd_cycle,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               overflow,
    output logic                     halted,
    output logic                     frozen
);
    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam logic [0:0]         c_ST_ARMED  = 1'b0;
    localparam logic [0:0]         c_ST_FROZEN = 1'b1;
    localparam logic [c_PTR_W:0]   c_CNT_FULL  = (c_PTR_W+1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_ONE   = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [CYC_W-1:0]   c_CYC_MAX   = '1;
    localparam logic [CYC_W-1:0]   c_CYC_ONE   = CYC_W'(1);
    localparam logic [CYC_W-1:0]   c_LIMIT     = CYC_W'(CYCLE_LIMIT);
    // A limit the counter can never reach must not alias after truncation.
    localparam bit c_LIMIT_EN = (CYCLE_LIMIT > 0) &&
                                (longint'(CYCLE_LIMIT) < (longint'(1) << CYC_W));
    localparam bit c_STOP     = (STOP_ON_FULL != 0);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [7:0]         r_ovf;
    logic [CYC_W-1:0]   r_cycle;
    logic               r_halted;

    logic [31:0]        r_mem_pc  [DEPTH];
    logic [31:0]        r_mem_wd  [DEPTH];
    logic [4:0]         r_mem_cls [DEPTH];
    logic [CYC_W-1:0]   r_mem_cyc [DEPTH];

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_cap;
    logic               w_blocked;
    logic               w_write;
    logic               w_rd_adv;
    logic               w_limit_hit;
    logic [4:0]         w_cls;

    function automatic logic [4:0] classify(input logic [31:0] instr);
        logic [4:0] cls;
        cls = 5'd0;
        if (instr == 32'd0) begin
            cls = 5'd10;
        end else if (instr[31:26] == 6'd0) begin
            case (instr[5:0])
                6'd32:   cls = 5'd1;
                6'd34:   cls = 5'd2;
                6'd36:   cls = 5'd3;
                6'd37:   cls = 5'd4;
                6'd42:   cls = 5'd5;
                6'd2:    cls = 5'd6;
                6'd25:   cls = 5'd7;
                6'd16:   cls = 5'd8;
                6'd18:   cls = 5'd9;
                default: cls = 5'd0;
            endcase
        end else begin
            case (instr[31:26])
                6'd35:   cls = 5'd11;
                6'd43:   cls = 5'd12;
                6'd4:    cls = 5'd13;
                6'd2:    cls = 5'd14;
                6'd9:    cls = 5'd15;
                6'd28:   cls = 5'd16;
                default: cls = 5'd0;
            endcase
        end
        return cls;
    endfunction

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_CNT_FULL);
    assign w_pop       = !w_empty && rd_ready;
    assign w_cap       = (r_state == c_ST_ARMED) && trc_valid;
    // Capture into a full buffer with no simultaneous pop to make room.
    assign w_blocked   = w_cap && w_full && !w_pop;
    assign w_write     = w_cap && !(w_blocked && c_STOP);
    assign w_rd_adv    = w_pop || (w_blocked && !c_STOP);
    assign w_limit_hit = c_LIMIT_EN && (r_state == c_ST_ARMED) && (r_cycle == c_LIMIT);
    assign w_cls       = classify(trc_instr);

    always_comb begin
        w_state_nxt = r_state;
        if (rearm) begin
            w_state_nxt = c_ST_ARMED;
        end else if ((r_state == c_ST_ARMED) && (w_limit_hit || (w_blocked && c_STOP))) begin
            w_state_nxt = c_ST_FROZEN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_ARMED;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 8'd0;
            r_cycle  <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (rearm) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_ovf    <= 8'd0;
                r_cycle  <= '0;
                r_halted <= 1'b0;
            end else begin
                if (w_write) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_rd_adv) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                if (w_write && !w_pop && !w_full) begin
                    r_count <= r_count + c_CNT_ONE;
                end else if (w_pop && !w_write) begin
                    r_count <= r_count - c_CNT_ONE;
                end
                if (w_blocked && (r_ovf != 8'hFF)) begin
                    r_ovf <= r_ovf + 8'd1;
                end
                if (r_cycle != c_CYC_MAX) begin
                    r_cycle <= r_cycle + c_CYC_ONE;
                end
                if (w_limit_hit) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; entries are only visible while count != 0.
    always_ff @(posedge clk) begin
        if (w_write && !rearm) begin
            r_mem_pc[r_wr_ptr]  <= trc_pc;
            r_mem_wd[r_wr_ptr]  <= trc_wd;
            r_mem_cls[r_wr_ptr] <= w_cls;
            r_mem_cyc[r_wr_ptr] <= r_cycle;
        end
    end

    assign rd_valid = !w_empty;
    assign rd_pc    = rd_valid ? r_mem_pc[r_rd_ptr]  : 32'd0;
    assign rd_wd    = rd_valid ? r_mem_wd[r_rd_ptr]  : 32'd0;
    assign rd_class = rd_valid ? r_mem_cls[r_rd_ptr] : 5'd0;
    assign rd_cycle = rd_valid ? r_mem_cyc[r_rd_ptr] : '0;
    assign count    = r_count;
    assign overflow = r_ovf;
    assign halted   = r_halted;
    assign frozen   = (r_state == c_ST_FROZEN);

endmodule
`default_nettype wire

// File: tb/tb_pipe_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_trace_buffer
// Brief    : Three trace-buffer configurations (wrap, freeze, cycle limit)
//            driven in lockstep and scored against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_pipe_trace_buffer;
    localparam int c_N = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] wd;
        logic [4:0]  cls;
        logic [15:0] cyc;
    } ent_t;

    typedef struct packed {
        logic       vld;
        logic [7:0] cnt;
        logic [7:0] ovf;
        logic       frz;
        logic       hlt;
    } st_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        trc_valid;
    logic [31:0] trc_pc;
    logic [31:0] trc_instr;
    logic [31:0] trc_wd;
    logic        rearm;
    logic        rd_ready;

    logic        vld_a, vld_b, vld_c;
    logic [31:0] pc_a, pc_b, pc_c;
    logic [31:0] wd_a, wd_b, wd_c;
    logic [4:0]  cls_a, cls_b, cls_c;
    logic [4:0]  cyc_a;
    logic [15:0] cyc_b, cyc_c;
    logic [2:0]  cnt_a, cnt_b;
    logic [4:0]  cnt_c;
    logic [7:0]  ovf_a, ovf_b, ovf_c;
    logic        hlt_a, hlt_b, hlt_c;
    logic        frz_a, frz_b, frz_c;

    always #5 clk = ~clk;

    pipe_trace_buffer #(.DEPTH(4), .CYC_W(5), .CYCLE_LIMIT(0), .STOP_ON_FULL(0)) u_wrap (
        .clk(clk), .rst(rst), .trc_valid(trc_valid), .trc_pc(trc_pc), .trc_instr(trc_instr),
        .trc_wd(trc_wd), .rearm(rearm), .rd_ready(rd_ready), .rd_valid(vld_a), .rd_pc(pc_a),
        .rd_wd(wd_a), .rd_class(cls_a), .rd_cycle(cyc_a), .count(cnt_a), .overflow(ovf_a),
        .halted(hlt_a), .frozen(frz_a));

    pipe_trace_buffer #(.DEPTH(4), .CYC_W(16), .CYCLE_LIMIT(0), .STOP_ON_FULL(1)) u_stop (
        .clk(clk), .rst(rst), .trc_valid(trc_valid), .trc_pc(trc_pc), .trc_instr(trc_instr),
        .trc_wd(trc_wd), .rearm(rearm), .rd_ready(rd_ready), .rd_valid(vld_b), .rd_pc(pc_b),
        .rd_wd(wd_b), .rd_class(cls_b), .rd_cycle(cyc_b), .count(cnt_b), .overflow(ovf_b),
        .halted(hlt_b), .frozen(frz_b));

    pipe_trace_buffer #(.DEPTH(16), .CYC_W(16), .CYCLE_LIMIT(10), .STOP_ON_FULL(0)) u_lim (
        .clk(clk), .rst(rst), .trc_valid(trc_valid), .trc_pc(trc_pc), .trc_instr(trc_instr),
        .trc_wd(trc_wd), .rearm(rearm), .rd_ready(rd_ready), .rd_valid(vld_c), .rd_pc(pc_c),
        .rd_wd(wd_c), .rd_class(cls_c), .rd_cycle(cyc_c), .count(cnt_c), .overflow(ovf_c),
        .halted(hlt_c), .frozen(frz_c));

    ent_t d_ent [c_N];
    st_t  d_st  [c_N];

    always_comb begin
        d_ent[0] = {pc_a, wd_a, cls_a, 11'd0, cyc_a};
        d_ent[1] = {pc_b, wd_b, cls_b, cyc_b};
        d_ent[2] = {pc_c, wd_c, cls_c, cyc_c};
        d_st[0]  = {vld_a, 5'd0, cnt_a, ovf_a, frz_a, hlt_a};
        d_st[1]  = {vld_b, 5'd0, cnt_b, ovf_b, frz_b, hlt_b};
        d_st[2]  = {vld_c, 3'd0, cnt_c, ovf_c, frz_c, hlt_c};
    end

    // Reference model: buffer contents as a plain queue per configuration.
    ent_t mq  [c_N][$];
    ent_t sbq [c_N][$];
    st_t  stq [c_N][$];
    int   m_ovf [c_N];
    int   m_cyc [c_N];
    bit   m_frz [c_N];
    bit   m_hlt [c_N];

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    function automatic int p_depth(input int i); return (i == 2) ? 16 : 4; endfunction
    function automatic bit p_stop(input int i);  return (i == 1); endfunction
    function automatic int p_limit(input int i); return (i == 2) ? 10 : 0; endfunction
    function automatic int p_cmax(input int i);  return (i == 0) ? 31 : 65535; endfunction

    function automatic logic [4:0] ref_class(input logic [31:0] w);
        int op;
        int fn;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        if (w == 32'd0) return 5'd10;
        if (op == 0) begin
            case (fn)
                32: return 5'd1;  34: return 5'd2;  36: return 5'd3;
                37: return 5'd4;  42: return 5'd5;  2:  return 5'd6;
                25: return 5'd7;  16: return 5'd8;  18: return 5'd9;
                default: return 5'd0;
            endcase
        end
        case (op)
            35: return 5'd11; 43: return 5'd12; 4:  return 5'd13;
            2:  return 5'd14; 9:  return 5'd15; 28: return 5'd16;
            default: return 5'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic st_t snap(input int i);
        st_t s;
        s.vld = (mq[i].size() != 0);
        s.cnt = 8'(mq[i].size());
        s.ovf = 8'(m_ovf[i]);
        s.frz = m_frz[i];
        s.hlt = m_hlt[i];
        return s;
    endfunction

    function automatic void model_reset(input int i);
        mq[i].delete();
        sbq[i].delete();
        stq[i].delete();
        m_ovf[i] = 0;
        m_cyc[i] = 0;
        m_frz[i] = 1'b0;
        m_hlt[i] = 1'b0;
    endfunction

    function automatic void model_step(input int i, input bit v, input logic [31:0] pc,
                                       input logic [31:0] instr, input logic [31:0] wd,
                                       input bit rdy, input bit rr);
        ent_t e;
        bit   pop;
        bit   cap;
        bit   full;
        if (rr) begin
            mq[i].delete();
            m_ovf[i] = 0;
            m_cyc[i] = 0;
            m_frz[i] = 1'b0;
            m_hlt[i] = 1'b0;
            return;
        end
        pop  = (mq[i].size() != 0) && rdy;
        cap  = v && !m_frz[i];
        full = (mq[i].size() == p_depth(i));
        e    = {pc, wd, ref_class(instr), 16'(m_cyc[i])};
        if (pop) begin
            sbq[i].push_back(mq[i][0]);
            void'(mq[i].pop_front());
        end
        if ((p_limit(i) != 0) && (m_cyc[i] == p_limit(i)) && !m_frz[i]) begin
            m_frz[i] = 1'b1;
            m_hlt[i] = 1'b1;
        end
        if (cap) begin
            if (full && !pop) begin
                if (m_ovf[i] < 255) m_ovf[i]++;
                if (p_stop(i)) begin
                    m_frz[i] = 1'b1;
                end else begin
                    void'(mq[i].pop_front());
                    mq[i].push_back(e);
                end
            end else begin
                mq[i].push_back(e);
            end
        end
        if (m_cyc[i] < p_cmax(i)) m_cyc[i]++;
    endfunction

    // Called just after a rising edge; the inputs apply to the next edge.
    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] wd, input bit rdy, input bit rr);
        trc_valid = v;
        trc_pc    = pc;
        trc_instr = instr;
        trc_wd    = wd;
        rd_ready  = rdy;
        rearm     = rr;
        for (int i = 0; i < c_N; i++) begin
            stq[i].push_back(snap(i));
            model_step(i, v, pc, instr, wd, rdy, rr);
        end
        mon_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: w = 32'd0;
            1: begin
                w[31:26] = 6'd0;
                case ($urandom_range(0, 9))
                    0: w[5:0] = 6'd32; 1: w[5:0] = 6'd34; 2: w[5:0] = 6'd36;
                    3: w[5:0] = 6'd37; 4: w[5:0] = 6'd42; 5: w[5:0] = 6'd2;
                    6: w[5:0] = 6'd25; 7: w[5:0] = 6'd16; 8: w[5:0] = 6'd18;
                    default: w[5:0] = 6'd0;
                endcase
            end
            2: begin
                case ($urandom_range(0, 5))
                    0: w[31:26] = 6'd35; 1: w[31:26] = 6'd43; 2: w[31:26] = 6'd4;
                    3: w[31:26] = 6'd2;  4: w[31:26] = 6'd9;  default: w[31:26] = 6'd28;
                endcase
            end
            default: ;
        endcase
        return w;
    endfunction

    // Monitor: status every cycle, popped entries whenever a handshake is presented.
    initial begin
        st_t  es;
        ent_t ee;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int i = 0; i < c_N; i++) begin
                    if (stq[i].size() == 0) begin
                        check($sformatf("status queue empty [%0d]", i), 128'd1, 128'd0);
                    end else begin
                        es = stq[i].pop_front();
                        check($sformatf("status [%0d]", i), 128'(d_st[i]), 128'(es));
                    end
                    if (d_st[i].vld && rd_ready && !rearm) begin
                        if (sbq[i].size() == 0) begin
                            check($sformatf("unexpected pop [%0d]", i), 128'(d_ent[i]), 128'd0);
                        end else begin
                            ee = sbq[i].pop_front();
                            check($sformatf("pop entry [%0d]", i), 128'(d_ent[i]), 128'(ee));
                        end
                    end
                end
            end
        end
    end

    logic [31:0] cls_words [5];
    logic [4:0]  cls_exp   [5];

    initial begin
        rst = 1'b0; trc_valid = 1'b0; trc_pc = '0; trc_instr = '0; trc_wd = '0;
        rearm = 1'b0; rd_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < c_N; i++) begin
            check($sformatf("reset status [%0d]", i), 128'(d_st[i]), 128'd0);
            check($sformatf("reset outputs [%0d]", i), 128'(d_ent[i]), 128'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < c_N; i++) model_reset(i);

        // Single ADD captured with cycle stamp 3.
        repeat (3) step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'd0, 32'h00221820, 32'd7, 1'b0, 1'b0);
        check("first rd_valid", 128'(vld_a), 128'd1);
        check("first rd_class", 128'(cls_a), 128'd1);
        check("first rd_pc", 128'(pc_a), 128'd0);
        check("first rd_wd", 128'(wd_a), 128'd7);
        check("first rd_cycle", 128'(cyc_a), 128'd3);
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);

        // Six captures into depth-4 buffers: wrap keeps newest, stop freezes.
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 32'(4 * k), 32'h00221820, 32'(k), 1'b0, 1'b0);
            if (k == 4) check("stop frozen after 5th", 128'(frz_b), 128'd1);
        end
        check("wrap count", 128'(cnt_a), 128'd4);
        check("wrap overflow", 128'(ovf_a), 128'd2);
        check("stop overflow", 128'(ovf_b), 128'd1);
        for (int k = 0; k < 4; k++) begin
            check("wrap pop pc", 128'(pc_a), 128'(8 + 4 * k));
            check("stop pop pc", 128'(pc_b), 128'(4 * k));
            step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        end
        step(1'b1, 32'd100, 32'h00221820, 32'd1, 1'b0, 1'b0);
        check("stop ignores capture", 128'(cnt_b), 128'd0);
        check("stop stays frozen", 128'(frz_b), 128'd1);

        // Cycle-limit halt with trc_valid held high.
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int k = 0; k < 14; k++) begin
            step(1'b1, 32'(4 * k), 32'h8C010004, 32'(k), 1'b0, 1'b0);
            check("limit halted", 128'(hlt_c), 128'(k >= 10));
        end
        check("limit count", 128'(cnt_c), 128'd11);
        for (int k = 0; k <= 10; k++) begin
            check("limit stamp", 128'(cyc_c), 128'(k));
            step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        end
        check("limit drained count", 128'(cnt_c), 128'd0);
        check("limit drained frozen", 128'(frz_c), 128'd1);
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        check("rearm halted", 128'(hlt_c), 128'd0);
        check("rearm frozen", 128'(frz_c), 128'd0);
        check("rearm count", 128'(cnt_c), 128'd0);

        // Instruction classes.
        cls_words = '{32'h00000000, 32'h8C010004, 32'h08000003, 32'h70000000, 32'h00011080};
        cls_exp   = '{5'd10, 5'd11, 5'd14, 5'd16, 5'd0};
        for (int k = 0; k < 5; k++) step(1'b1, 32'(k), cls_words[k], 32'd0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("class of %h", cls_words[k]), 128'(cls_c), 128'(cls_exp[k]));
            step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        end

        // Asynchronous reset in the middle of a drain.
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 32'(k), 32'h00221820, 32'd0, 1'b0, 1'b0);
        check("pre-reset count", 128'(cnt_a), 128'd3);
        mon_en = 1'b0;
        trc_valid = 1'b0;
        rd_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async reset count", 128'(cnt_a), 128'd0);
        check("async reset rd_valid", 128'(vld_a), 128'd0);
        for (int i = 0; i < c_N; i++) begin
            check($sformatf("async reset status [%0d]", i), 128'(d_st[i]), 128'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < c_N; i++) model_reset(i);

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            step(($urandom_range(0, 2) != 0), $urandom, rand_instr(), $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
        end
        mon_en = 1'b0;
        for (int i = 0; i < c_N; i++) begin
            check($sformatf("pending pops [%0d]", i), 128'(sbq[i].size()), 128'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
